// File: rtl/hazard_pkg.sv
// Shared definitions for the RV32I hazard controller: FSM state encoding,
// pipeline NOP encoding and the load-use detection helper.
package hazard_pkg;

  localparam int          REG_W    = 5;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_MD_BUSY  = 2'd1;
  localparam state_t ST_MD_DRAIN = 2'd2;

  // rs2 only counts when the decode instruction actually reads it (R/S/B types)
  function automatic logic load_use_hazard(
    input logic             mem_read,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2,
    input logic             uses_rs2
  );
    return mem_read && (rd != {REG_W{1'b0}}) &&
           ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count: step only while enabled and not yet saturated
  always_comb begin
    count_d = count_q;
    if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stalls, taken-branch flushes and mul/div
// occupancy of EX with a watchdog; counts every cycle the PC is held.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int MD_MAX = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IF_ID_Rs1,
  input  logic [REG_W-1:0] IF_ID_Rs2,
  input  logic             IF_ID_UsesRs2,
  input  logic [REG_W-1:0] ID_EX_Rd,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_MulDiv,
  input  logic             Md_Done,
  input  logic             EX_BranchTaken,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Bubble,
  output logic             Md_Start,
  output logic             Md_Timeout,
  output logic [CNT_W-1:0] Stall_Count
);

  localparam int WD_W = $clog2(MD_MAX + 1);

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            md_timeout_q, md_timeout_d;
  logic            lu_hazard_s;

  assign lu_hazard_s = load_use_hazard(ID_EX_MemRead, ID_EX_Rd, IF_ID_Rs1,
                                       IF_ID_Rs2, IF_ID_UsesRs2);

  // control outputs and next state; while reset is held everything sits at its idle value
  always_comb begin
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    EX_MEM_Bubble = 1'b0;
    Md_Start      = 1'b0;
    state_d       = state_q;
    md_timeout_d  = md_timeout_q;
    wd_d          = {WD_W{1'b0}};
    if (!rst) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          // a taken branch makes the decode instruction wrong-path, so it wins over load-use
          if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
          end else if (ID_EX_MulDiv) begin
            Md_Start = 1'b1;
            state_d  = ST_MD_BUSY;
          end else if (lu_hazard_s) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_MD_BUSY: begin
          PC_Write      = 1'b0;
          IF_ID_Write   = 1'b0;
          ID_EX_Write   = 1'b0;
          EX_MEM_Bubble = 1'b1;
          wd_d          = wd_q + WD_W'(1);
          if (Md_Done) begin
            state_d = ST_MD_DRAIN;
          end else if (wd_q == WD_W'(MD_MAX - 1)) begin
            md_timeout_d = 1'b1;
            state_d      = ST_MD_DRAIN;
          end else begin
            state_d = ST_MD_BUSY;
          end
        end
        ST_MD_DRAIN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // FSM state, watchdog count and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      wd_q         <= {WD_W{1'b0}};
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  assign Md_Timeout = md_timeout_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (~PC_Write),
    .count(Stall_Count)
  );

endmodule
